// File: rtl/k423_ex_bpu_upd_pkg.sv
// Shared widths, update-beat payload and next-PC helper for the EX-stage BPU update path.
`include "k423_defines.svh"

package k423_ex_bpu_upd_pkg;

   localparam int unsigned CORE_DATA_W = `CORE_DATA_W;
   localparam int unsigned BR_TYPE_W   = `BR_TYPE_W;
   localparam int unsigned BR_COND     = `BR_TYPE_COND;
   localparam logic [1:0]  SAT_MAX     = `SAT_MAX;

   typedef struct packed {
      logic                   tkn;
      logic [BR_TYPE_W-1:0]   br_type;
      logic [CORE_DATA_W-1:0] src_pc;
      logic [CORE_DATA_W-1:0] tgt_pc;
      logic [1:0]             sat_cnt;
   } upd_beat_t;

   // Architectural next PC; the fall-through wraps modulo 2^CORE_DATA_W.
   function automatic logic [CORE_DATA_W-1:0] next_pc(
      input logic [CORE_DATA_W-1:0] pc,
      input logic                   tkn,
      input logic [CORE_DATA_W-1:0] tgt
   );
      return tkn ? tgt : pc + CORE_DATA_W'(4);
   endfunction

endpackage

// File: rtl/k423_ex_bpu_upd_if.sv
// Resolved-branch input, BPU update bus, flush and IF redirect handshake.
interface k423_ex_bpu_upd_if
   import k423_ex_bpu_upd_pkg::*;
#(
   parameter int unsigned MISP_CNT_W = 32
);
   logic                   res_vld_i;
   logic                   res_rdy_o;
   logic [BR_TYPE_W-1:0]   res_type_i;
   logic [CORE_DATA_W-1:0] res_pc_i;
   logic                   res_tkn_i;
   logic [CORE_DATA_W-1:0] res_tgt_i;
   logic                   prd_tkn_i;
   logic [CORE_DATA_W-1:0] prd_tgt_i;
   logic [1:0]             prd_sat_cnt_i;

   logic                   upd_vld_o;
   logic                   upd_tkn_o;
   logic [BR_TYPE_W-1:0]   upd_type_o;
   logic [CORE_DATA_W-1:0] upd_src_pc_o;
   logic [CORE_DATA_W-1:0] upd_tgt_pc_o;
   logic [1:0]             upd_sat_cnt_o;

   logic                   flush_o;
   logic                   redir_vld_o;
   logic [CORE_DATA_W-1:0] redir_pc_o;
   logic                   redir_rdy_i;
   logic [MISP_CNT_W-1:0]  misp_cnt_o;

   modport master (
      output res_vld_i, res_type_i, res_pc_i, res_tkn_i, res_tgt_i,
             prd_tkn_i, prd_tgt_i, prd_sat_cnt_i, redir_rdy_i,
      input  res_rdy_o, upd_vld_o, upd_tkn_o, upd_type_o, upd_src_pc_o,
             upd_tgt_pc_o, upd_sat_cnt_o, flush_o, redir_vld_o, redir_pc_o,
             misp_cnt_o
   );

   modport slave (
      input  res_vld_i, res_type_i, res_pc_i, res_tkn_i, res_tgt_i,
             prd_tkn_i, prd_tgt_i, prd_sat_cnt_i, redir_rdy_i,
      output res_rdy_o, upd_vld_o, upd_tkn_o, upd_type_o, upd_src_pc_o,
             upd_tgt_pc_o, upd_sat_cnt_o, flush_o, redir_vld_o, redir_pc_o,
             misp_cnt_o
   );

endinterface

// File: rtl/k423_defines.svh
// Shared branch-type bit indices, core data width and 2-bit PHT counter limits.
`ifndef K423_DEFINES_SVH
`define K423_DEFINES_SVH

`define BR_TYPE_COND 0
`define BR_TYPE_JAL  1
`define BR_TYPE_JALR 2
`define BR_TYPE_CALL 3
`define BR_TYPE_RET  4
`define BR_TYPE_W    5

`define CORE_DATA_W  32

`define SAT_MAX      2'b11
`define SAT_MIN      2'b00

`endif

// File: rtl/utils_sat_cnt.sv
// Saturating up/down counter next-value logic; holds at all-ones going up and zero going down.
module utils_sat_cnt #(
   parameter int unsigned W = 2
) (
   input  logic [W-1:0] cnt,
   input  logic         up,
   input  logic         en,
   output logic [W-1:0] nxt_c
);

   localparam logic [W-1:0] CNT_MAX = '1;

   always_comb begin
      nxt_c = cnt;
      if (en) begin
         if (up) begin
            if (cnt != CNT_MAX) nxt_c = cnt + W'(1);
         end else begin
            if (cnt != '0) nxt_c = cnt - W'(1);
         end
      end
   end

endmodule

// File: rtl/k423_ex_bpu_upd.sv
// EX-stage branch resolution: one registered BPU update beat per resolved branch,
// plus flush and a held IF redirect on mispredict.
module k423_ex_bpu_upd
   import k423_ex_bpu_upd_pkg::*;
#(
   parameter int unsigned MISP_CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   k423_ex_bpu_upd_if.slave bus
);

   typedef enum logic {
      IDLE,
      REDIR
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic                   res_rdy_c;
   logic                   acc_c;
   logic                   misp_c;
   logic                   load_redir_c;
   logic [CORE_DATA_W-1:0] act_npc_c;
   logic [1:0]             pht_nxt_c;
   logic [1:0]             new_cnt_c;
   logic [MISP_CNT_W-1:0]  misp_nxt_c;

   upd_beat_t              upd_q;
   logic                   upd_vld_q;
   logic                   flush_q;
   logic                   redir_vld_q;
   logic [CORE_DATA_W-1:0] redir_pc_q;
   logic [MISP_CNT_W-1:0]  misp_cnt_q;

   assign res_rdy_c = (state_q == IDLE) & ~rst_i;
   assign acc_c     = bus.res_vld_i & res_rdy_c;
   assign act_npc_c = next_pc(bus.res_pc_i, bus.res_tkn_i, bus.res_tgt_i);
   assign misp_c    = (bus.prd_tkn_i != bus.res_tkn_i) |
                      (bus.res_tkn_i & (bus.prd_tgt_i != bus.res_tgt_i));

   // Only conditional branches train the direction counter; jumps pin it strongly taken.
   utils_sat_cnt #(.W(2)) u_pht_cnt (
      .cnt   (bus.prd_sat_cnt_i),
      .up    (bus.res_tkn_i),
      .en    (1'b1),
      .nxt_c (pht_nxt_c)
   );

   assign new_cnt_c = bus.res_type_i[BR_COND] ? pht_nxt_c : SAT_MAX;

   utils_sat_cnt #(.W(MISP_CNT_W)) u_misp_cnt (
      .cnt   (misp_cnt_q),
      .up    (1'b1),
      .en    (load_redir_c),
      .nxt_c (misp_nxt_c)
   );

   // Next-state logic; a mispredict accept is only possible from IDLE.
   always_comb begin
      state_d      = state_q;
      load_redir_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (acc_c && misp_c) begin
               state_d      = REDIR;
               load_redir_c = 1'b1;
            end
         end
         REDIR: begin
            if (bus.redir_rdy_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         upd_q       <= '0;
         upd_vld_q   <= 1'b0;
         flush_q     <= 1'b0;
         redir_vld_q <= 1'b0;
         redir_pc_q  <= '0;
         misp_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         upd_vld_q   <= acc_c;
         flush_q     <= load_redir_c;
         redir_vld_q <= (state_d == REDIR);
         misp_cnt_q  <= misp_nxt_c;
         if (load_redir_c) redir_pc_q <= act_npc_c;
         if (acc_c) begin
            upd_q.tkn     <= bus.res_tkn_i;
            upd_q.br_type <= bus.res_type_i;
            upd_q.src_pc  <= bus.res_pc_i;
            upd_q.tgt_pc  <= bus.res_tgt_i;
            upd_q.sat_cnt <= new_cnt_c;
         end
      end
   end

   assign bus.res_rdy_o     = res_rdy_c;
   assign bus.upd_vld_o     = upd_vld_q;
   assign bus.upd_tkn_o     = upd_q.tkn;
   assign bus.upd_type_o    = upd_q.br_type;
   assign bus.upd_src_pc_o  = upd_q.src_pc;
   assign bus.upd_tgt_pc_o  = upd_q.tgt_pc;
   assign bus.upd_sat_cnt_o = upd_q.sat_cnt;
   assign bus.flush_o       = flush_q;
   assign bus.redir_vld_o   = redir_vld_q;
   assign bus.redir_pc_o    = redir_pc_q;
   assign bus.misp_cnt_o    = misp_cnt_q;

endmodule

// File: tb/tb_k423_ex_bpu_upd.sv
// Bench for k423_ex_bpu_upd: directed vector table, saturation sequence and
// randomized traffic against a cycle-level reference model.
module tb_k423_ex_bpu_upd;
   import k423_ex_bpu_upd_pkg::*;

   localparam int unsigned MCW = 4;

   logic clk = 1'b0;
   logic rst;

   k423_ex_bpu_upd_if #(.MISP_CNT_W(MCW)) bus ();

   k423_ex_bpu_upd #(.MISP_CNT_W(MCW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [4:0]  ty;
      logic [31:0] pc;
      logic        tkn;
      logic [31:0] tgt;
      logic        ptkn;
      logic [31:0] ptgt;
      logic [1:0]  cnt;
      logic        rdy;
      logic        e_rdy;
      logic        e_uv;
      logic [1:0]  e_ucnt;
      logic        e_fl;
      logic        e_rv;
      logic [31:0] e_rpc;
      logic [3:0]  e_mc;
      logic        e_zero;
   } row_t;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit          m_redir;
   logic [31:0] m_rpc;
   int          m_mc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic row_t vec(
      input logic rst, input logic vld, input logic [4:0] ty, input logic [31:0] pc,
      input logic tkn, input logic [31:0] tgt, input logic ptkn, input logic [31:0] ptgt,
      input logic [1:0] cnt, input logic rdy,
      input logic e_rdy, input logic e_uv, input logic [1:0] e_ucnt, input logic e_fl,
      input logic e_rv, input logic [31:0] e_rpc, input logic [3:0] e_mc, input logic e_zero);
      row_t r;
      r.rst = rst; r.vld = vld; r.ty = ty; r.pc = pc; r.tkn = tkn; r.tgt = tgt;
      r.ptkn = ptkn; r.ptgt = ptgt; r.cnt = cnt; r.rdy = rdy;
      r.e_rdy = e_rdy; r.e_uv = e_uv; r.e_ucnt = e_ucnt; r.e_fl = e_fl;
      r.e_rv = e_rv; r.e_rpc = e_rpc; r.e_mc = e_mc; r.e_zero = e_zero;
      return r;
   endfunction

   // Expected outputs from the behavioural rules; advances the model by one cycle.
   task automatic model_fill(inout row_t r);
      bit          acc;
      bit          misp;
      logic [31:0] npc;
      int          c;
      if (r.rst) begin
         m_redir = 0; m_mc = 0; m_rpc = '0;
         r.e_rdy = 0; r.e_uv = 0; r.e_ucnt = 0; r.e_fl = 0;
         r.e_rv = 0; r.e_rpc = 0; r.e_mc = 0; r.e_zero = 1;
         return;
      end
      r.e_zero = 0;
      r.e_rdy  = !m_redir;
      acc  = r.vld && !m_redir;
      misp = (r.ptkn != r.tkn) || (r.tkn && (r.ptgt != r.tgt));
      npc  = r.tkn ? r.tgt : r.pc + 32'd4;
      c    = int'(r.cnt);
      if (r.ty[0]) c = r.tkn ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
      else         c = 3;
      r.e_uv   = acc;
      r.e_ucnt = 2'(c);
      r.e_fl   = acc && misp;
      if (m_redir && r.rdy) m_redir = 0;
      if (acc && misp) begin
         m_redir = 1;
         m_rpc   = npc;
         if (m_mc < 15) m_mc++;
      end
      r.e_rv  = m_redir;
      r.e_rpc = m_rpc;
      r.e_mc  = 4'(m_mc);
   endtask

   task automatic apply_row(input row_t r);
      rst               = r.rst;
      bus.res_vld_i     = r.vld;
      bus.res_type_i    = r.ty;
      bus.res_pc_i      = r.pc;
      bus.res_tkn_i     = r.tkn;
      bus.res_tgt_i     = r.tgt;
      bus.prd_tkn_i     = r.ptkn;
      bus.prd_tgt_i     = r.ptgt;
      bus.prd_sat_cnt_i = r.cnt;
      bus.redir_rdy_i   = r.rdy;
      #1;
      chk("res_rdy", 32'(bus.res_rdy_o), 32'(r.e_rdy));
      @(posedge clk);
      #1;
      chk("upd_vld", 32'(bus.upd_vld_o), 32'(r.e_uv));
      chk("flush", 32'(bus.flush_o), 32'(r.e_fl));
      chk("redir_vld", 32'(bus.redir_vld_o), 32'(r.e_rv));
      chk("misp_cnt", 32'(bus.misp_cnt_o), 32'(r.e_mc));
      if (r.e_rv) chk("redir_pc", bus.redir_pc_o, r.e_rpc);
      if (r.e_zero) begin
         chk("rst_upd_tkn", 32'(bus.upd_tkn_o), 32'd0);
         chk("rst_upd_type", 32'(bus.upd_type_o), 32'd0);
         chk("rst_upd_src", bus.upd_src_pc_o, 32'd0);
         chk("rst_upd_tgt", bus.upd_tgt_pc_o, 32'd0);
         chk("rst_upd_cnt", 32'(bus.upd_sat_cnt_o), 32'd0);
         chk("rst_redir_pc", bus.redir_pc_o, 32'd0);
      end else if (r.e_uv) begin
         chk("upd_tkn", 32'(bus.upd_tkn_o), 32'(r.tkn));
         chk("upd_type", 32'(bus.upd_type_o), 32'(r.ty));
         chk("upd_src", bus.upd_src_pc_o, r.pc);
         chk("upd_tgt", bus.upd_tgt_pc_o, r.tgt);
         chk("upd_cnt", 32'(bus.upd_sat_cnt_o), 32'(r.e_ucnt));
      end
   endtask

   localparam logic [4:0] T_COND = 5'b00001;
   localparam logic [4:0] T_RET  = 5'b10000;

   row_t tbl[$];
   row_t r;

   initial begin
      // rst vld ty pc tkn tgt ptkn ptgt cnt rdy | e_rdy e_uv e_ucnt e_fl e_rv e_rpc e_mc e_zero
      tbl.push_back(vec(1, 0, T_COND, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0,  0, 0, 0, 0, 0, 32'h0,   0, 1));
      tbl.push_back(vec(1, 0, T_COND, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0,  0, 0, 0, 0, 0, 32'h0,   0, 1));
      tbl.push_back(vec(0, 1, T_COND, 32'h100, 1, 32'h200, 1, 32'h200, 2, 0,  1, 1, 3, 0, 0, 32'h0,   0, 0));
      tbl.push_back(vec(0, 1, T_COND, 32'h100, 1, 32'h200, 1, 32'h200, 2, 0,  1, 1, 3, 0, 0, 32'h0,   0, 0));
      tbl.push_back(vec(0, 1, T_COND, 32'h100, 1, 32'h200, 1, 32'h200, 2, 0,  1, 1, 3, 0, 0, 32'h0,   0, 0));
      tbl.push_back(vec(0, 1, T_COND, 32'h100, 0, 32'h200, 1, 32'h200, 0, 0,  1, 1, 0, 1, 1, 32'h104, 1, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(vec(0, 1, T_COND, 32'h100, 0, 32'h200, 1, 32'h200, 0, 0,  0, 0, 0, 0, 1, 32'h104, 1, 0));
      tbl.push_back(vec(0, 0, T_COND, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1,  0, 0, 0, 0, 0, 32'h0,   1, 0));
      tbl.push_back(vec(0, 1, T_RET,  32'h300, 1, 32'h480, 1, 32'h400, 1, 0,  1, 1, 3, 1, 1, 32'h480, 2, 0));
      tbl.push_back(vec(0, 0, T_COND, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1,  0, 0, 0, 0, 0, 32'h0,   2, 0));
      tbl.push_back(vec(0, 1, T_COND, 32'hFFFF_FFFC, 0, 32'h50, 1, 32'h50, 3, 0,  1, 1, 2, 1, 1, 32'h0, 3, 0));
      tbl.push_back(vec(0, 0, T_COND, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1,  0, 0, 0, 0, 0, 32'h0,   3, 0));
      tbl.push_back(vec(0, 1, T_COND, 32'h40,  1, 32'h80,  0, 32'h80,  1, 0,  1, 1, 2, 1, 1, 32'h80,  4, 0));
      tbl.push_back(vec(1, 1, T_COND, 32'h40,  1, 32'h80,  0, 32'h80,  1, 0,  0, 0, 0, 0, 0, 32'h0,   0, 1));
      tbl.push_back(vec(0, 0, T_COND, 32'h40,  1, 32'h80,  0, 32'h80,  1, 0,  1, 0, 0, 0, 0, 32'h0,   0, 0));

      foreach (tbl[i]) apply_row(tbl[i]);

      // Mispredict counter saturation, expectations from the model.
      r = vec(1, 0, T_COND, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      model_fill(r); apply_row(r);
      for (int k = 0; k < 17; k++) begin
         r = vec(0, 1, T_COND, 32'h500, 1, 32'h600, 0, 32'h600, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
         model_fill(r); apply_row(r);
         r = vec(0, 0, T_COND, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
         model_fill(r); apply_row(r);
      end
      chk("misp_sat", 32'(bus.misp_cnt_o), 32'hF);

      // Randomized traffic.
      r = vec(1, 0, T_COND, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      model_fill(r); apply_row(r);
      for (int k = 0; k < 400; k++) begin
         logic [4:0] types [6];
         types = '{5'b00001, 5'b00010, 5'b00100, 5'b01010, 5'b10100, 5'b10000};
         r.rst  = ($urandom_range(0, 99) < 3);
         r.vld  = ($urandom_range(0, 3) != 0);
         r.ty   = types[$urandom_range(0, 5)];
         r.pc   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         r.tkn  = 1'($urandom_range(0, 1));
         r.tgt  = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
         r.ptkn = ($urandom_range(0, 9) < 7) ? r.tkn : ~r.tkn;
         r.ptgt = ($urandom_range(0, 9) < 7) ? r.tgt : 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
         r.cnt  = 2'($urandom_range(0, 3));
         r.rdy  = 1'($urandom_range(0, 1));
         model_fill(r);
         apply_row(r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
